// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the pipelined CPU. Owns the program counter,
// keeps at most one word read outstanding to instruction memory and fills
// the IF/ID pipeline register (instruction, PC, PC+4) consumed by decode.
// Handles hazard-unit stalls through a one-entry skid buffer, branch
// redirects with flush, and memories of any response latency.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   imem_req          registered read request
//   imem_addr         registered word address (bits [1:0] always 0)
//   imem_rvalid       response valid, closes the current transaction
//   imem_rdata        instruction word, used only with imem_rvalid
//   id_stall          hazard unit asks IF/ID to hold its contents
//   redirect_valid    take redirect_pc and flush IF/ID
//   redirect_pc       redirect target from the next-PC mux
//   id_valid          IF/ID holds a live instruction
//   id_instr          IF/ID instruction
//   id_pc             address of id_instr
//   id_pc_plus4       id_pc + 4, fed to next-PC mux input1
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
);

   // IDLE  : one cycle after reset before the first request goes out
   // FETCH : a request is outstanding
   // HOLD  : a response arrived while decode was stalled; it sits in the skid
   // DRAIN : a redirect arrived mid-transaction; the stale response is awaited
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] pending_pc_q, pending_pc_d;

   logic [31:0] redirect_aligned;
   logic [31:0] pc_plus4;
   logic [31:0] drain_target;

   // Low address bits of a redirect are dropped so every fetch stays word aligned.
   assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
   assign pc_plus4         = pc_q + 32'd4;
   // A redirect arriving in the same cycle as the stale response still wins.
   assign drain_target     = redirect_valid ? redirect_aligned : pending_pc_q;

   // Next-state logic. imem_addr always tracks pc while a request is live, so
   // both are updated together whenever the fetch address moves.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_d        = req_q;
      addr_d       = addr_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      id_pc_d      = id_pc_q;
      id_pc4_d     = id_pc4_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      pending_pc_d = pending_pc_q;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = pc_q;
         end

         FETCH: begin
            if (imem_rvalid) begin
               if (redirect_valid) begin
                  pc_d    = redirect_aligned;
                  addr_d  = redirect_aligned;
                  valid_d = 1'b0;
               end else if (!id_stall || !valid_q) begin
                  valid_d  = 1'b1;
                  instr_d  = imem_rdata;
                  id_pc_d  = pc_q;
                  id_pc4_d = pc_plus4;
                  pc_d     = pc_plus4;
                  addr_d   = pc_plus4;
               end else begin
                  skid_instr_d = imem_rdata;
                  skid_pc_d    = pc_q;
                  pc_d         = pc_plus4;
                  addr_d       = pc_plus4;
                  req_d        = 1'b0;
                  state_d      = HOLD;
               end
            end else if (redirect_valid) begin
               pending_pc_d = redirect_aligned;
               valid_d      = 1'b0;
               state_d      = DRAIN;
            end else if (!id_stall) begin
               valid_d = 1'b0;
            end
         end

         HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirect_aligned;
               addr_d  = redirect_aligned;
               req_d   = 1'b1;
               valid_d = 1'b0;
               state_d = FETCH;
            end else if (!id_stall) begin
               valid_d  = 1'b1;
               instr_d  = skid_instr_q;
               id_pc_d  = skid_pc_q;
               id_pc4_d = skid_pc_q + 32'd4;
               req_d    = 1'b1;
               addr_d   = pc_q;
               state_d  = FETCH;
            end
         end

         DRAIN: begin
            if (redirect_valid) begin
               pending_pc_d = redirect_aligned;
            end
            if (imem_rvalid) begin
               pc_d    = drain_target;
               addr_d  = drain_target;
               state_d = FETCH;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and pipeline registers; reset puts everything back to its
   // power-on values immediately, dropping any response in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         req_q        <= 1'b0;
         addr_q       <= RESET_PC;
         valid_q      <= 1'b0;
         instr_q      <= 32'h0;
         id_pc_q      <= 32'h0;
         id_pc4_q     <= 32'h0;
         skid_instr_q <= 32'h0;
         skid_pc_q    <= 32'h0;
         pending_pc_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         id_pc_q      <= id_pc_d;
         id_pc4_q     <= id_pc4_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         pending_pc_q <= pending_pc_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign id_valid    = valid_q;
   assign id_instr    = instr_q;
   assign id_pc       = id_pc_q;
   assign id_pc_plus4 = id_pc4_q;

endmodule
